ok_wire_or_pipe: RTL and testbench

OK_WIRE_OR_PIPE -- requirements
Module: ok_wire_or_pipe

---
 rtl/ok_wire_or_pipe.sv | 124 ++++++++++++
 tb/tb_ok_wire_or_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ok_wire_or_pipe.sv
// ok_wire_or_pipe
//   Wired-OR combiner for N endpoint-to-host buses with an optional collision
//   monitor. Each enabled channel slice is OR-ed into one W-bit word that travels
//   through a STAGES-deep register pipeline to okEH.
//
//   Optional feature macro: OK_WIREOR_COLLDET_EN
//     defined   -> collision detection, pulse pipeline and statistics are built
//     undefined -> collision/statistics outputs are tied to 0, clr_stat ignored
//
//   Ports
//     okClk        in   1      clock, rising edge
//     okRst_n      in   1      synchronous active-low reset
//     okEHx        in   N*W    channel i at bits [i*W +: W]
//     chan_en      in   N      per-channel enable (low forces channel to zero)
//     clr_stat     in   1      clear collision statistics
//     okEH         out  W      OR of enabled slices, STAGES cycles later
//     collision    out  1      two or more channels active in the sample of okEH
//     coll_sticky  out  1      set by any collision until clear/reset
//     coll_count   out  16     saturating collision count
//     coll_chan    out  N      activity mask of the first collision since clear/reset
module ok_wire_or_pipe #(
   parameter int unsigned N      = 1,
   parameter int unsigned W      = 65,
   parameter int unsigned STAGES = 1
) (
   input  logic             okClk,
   input  logic             okRst_n,
   input  logic [N*W-1:0]   okEHx,
   input  logic [N-1:0]     chan_en,
   input  logic             clr_stat,
   output logic [W-1:0]     okEH,
   output logic             collision,
   output logic             coll_sticky,
   output logic [15:0]      coll_count,
   output logic [N-1:0]     coll_chan
);

   logic [W-1:0] w_or;
   logic [N-1:0] w_act;
   logic [W-1:0] r_data [STAGES];

   // Disabled channels contribute nothing, so their bits (X or not) never reach okEH.
   always_comb begin
      w_or  = '0;
      w_act = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (chan_en[i]) begin
            w_or     = w_or | okEHx[i*W +: W];
            w_act[i] = |okEHx[i*W +: W];
         end
      end
   end

   always_ff @(posedge okClk) begin
      if (!okRst_n) begin
         for (int unsigned s = 0; s < STAGES; s++) r_data[s] <= '0;
      end else begin
         r_data[0] <= w_or;
         for (int unsigned s = 1; s < STAGES; s++) r_data[s] <= r_data[s-1];
      end
   end

   assign okEH = r_data[STAGES-1];

`ifdef OK_WIREOR_COLLDET_EN
   logic         w_multi;
   logic         r_coll [STAGES];
   logic [N-1:0] r_mask [STAGES];
   logic         r_sticky;
   logic [15:0]  r_count;
   logic [N-1:0] r_chan;

   // x & (x-1) clears the lowest set bit; anything left means two or more active.
   assign w_multi = (w_act & (w_act - 1'b1)) != '0;

   // Collision flag and its mask ride alongside the data word so they emerge together.
   always_ff @(posedge okClk) begin
      if (!okRst_n) begin
         for (int unsigned s = 0; s < STAGES; s++) begin
            r_coll[s] <= 1'b0;
            r_mask[s] <= '0;
         end
      end else begin
         r_coll[0] <= w_multi;
         r_mask[0] <= w_act;
         for (int unsigned s = 1; s < STAGES; s++) begin
            r_coll[s] <= r_coll[s-1];
            r_mask[s] <= r_mask[s-1];
         end
      end
   end

   assign collision = r_coll[STAGES-1];

   // A clear coinciding with a collision restarts the statistics from that collision.
   always_ff @(posedge okClk) begin
      if (!okRst_n) begin
         r_sticky <= 1'b0;
         r_count  <= '0;
         r_chan   <= '0;
      end else if (clr_stat) begin
         r_sticky <= collision;
         r_count  <= collision ? 16'd1 : 16'd0;
         r_chan   <= collision ? r_mask[STAGES-1] : '0;
      end else if (collision) begin
         r_sticky <= 1'b1;
         if (r_count != '1) r_count <= r_count + 16'd1;
         if (!r_sticky)     r_chan  <= r_mask[STAGES-1];
      end
   end

   assign coll_sticky = r_sticky;
   assign coll_count  = r_count;
   assign coll_chan   = r_chan;
`else
   logic w_unused;
   assign w_unused    = ^{clr_stat, w_act};
   assign collision   = 1'b0;
   assign coll_sticky = 1'b0;
   assign coll_count  = '0;
   assign coll_chan   = '0;
`endif

endmodule

// File: tb/tb_ok_wire_or_pipe.sv
// Testbench for ok_wire_or_pipe: two instances (STAGES=2 and STAGES=3, N=4, W=65)
// share one stimulus stream. Expected words are queued per instance, tagged with
// the edge at which they must appear; a monitor pops and compares every cycle and
// keeps its own statistics model.
`timescale 1ns/1ps
module tb_ok_wire_or_pipe;
   localparam int N = 4;
   localparam int W = 65;
`ifdef OK_WIREOR_COLLDET_EN
   localparam bit CD = 1'b1;
`else
   localparam bit CD = 1'b0;
`endif

   typedef struct {
      int           emerge;
      logic [W-1:0] data;
      bit           coll;
      logic [N-1:0] mask;
   } entry_t;

   logic           okClk = 1'b0;
   logic           okRst_n;
   logic [N*W-1:0] okEHx;
   logic [N-1:0]   chan_en;
   logic           clr_stat;

   logic [W-1:0]   eh     [2];
   logic           coll   [2];
   logic           sticky [2];
   logic [15:0]    cnt    [2];
   logic [N-1:0]   chan   [2];

   int     edge_cnt = 0;
   int     n_cmp = 0;
   int     n_err = 0;
   entry_t sb [2][$];
   bit     clr_at [int];
   bit     rst_at [int];

   always #5 okClk = ~okClk;
   always @(posedge okClk) edge_cnt <= edge_cnt + 1;

   ok_wire_or_pipe #(.N(N), .W(W), .STAGES(2)) u_s2 (
      .okClk(okClk), .okRst_n(okRst_n), .okEHx(okEHx), .chan_en(chan_en),
      .clr_stat(clr_stat), .okEH(eh[0]), .collision(coll[0]),
      .coll_sticky(sticky[0]), .coll_count(cnt[0]), .coll_chan(chan[0]));

   ok_wire_or_pipe #(.N(N), .W(W), .STAGES(3)) u_s3 (
      .okClk(okClk), .okRst_n(okRst_n), .okEHx(okEHx), .chan_en(chan_en),
      .clr_stat(clr_stat), .okEH(eh[1]), .collision(coll[1]),
      .coll_sticky(sticky[1]), .coll_count(cnt[1]), .coll_chan(chan[1]));

   function automatic int stg(int d);
      return (d == 0) ? 2 : 3;
   endfunction

   function automatic logic [N*W-1:0] mk(logic [W-1:0] c0, logic [W-1:0] c1,
                                         logic [W-1:0] c2, logic [W-1:0] c3);
      return {c3, c2, c1, c0};
   endfunction

   function automatic logic [W-1:0] rnd_slice();
      logic [W-1:0] v;
      v = W'({$urandom, $urandom, $urandom});
      if ($urandom_range(0, 1) == 0) v = '0;
      return v;
   endfunction

   task automatic check(string name, int d, logic [127:0] got, logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s dut%0d edge %0d: got %0h expected %0h", name, d, edge_cnt, got, exp);
      end
   endtask

   // Apply one input sample for the next rising edge and queue what it must produce.
   task automatic step(bit rst, logic [N-1:0] en, logic [N*W-1:0] x, bit clr);
      int           k;
      logic [W-1:0] d_or;
      logic [N-1:0] act;
      entry_t       e;
      entry_t       t;
      okRst_n  = ~rst;
      chan_en  = en;
      okEHx    = x;
      clr_stat = clr;
      k = edge_cnt + 1;
      clr_at[k] = clr;
      rst_at[k] = rst;
      d_or = '0;
      act  = '0;
      for (int i = 0; i < N; i++) begin
         logic [W-1:0] sl;
         sl = W'(x >> (i * W));
         if (en[i] && sl != '0) begin
            d_or   = d_or | sl;
            act[i] = 1'b1;
         end
      end
      for (int d = 0; d < 2; d++) begin
         e.emerge = k + stg(d) - 1;
         if (rst) begin
            e.data = '0; e.coll = 1'b0; e.mask = '0;
            // words still in flight are lost
            for (int j = 0; j < sb[d].size(); j++) begin
               if (sb[d][j].emerge >= k) begin
                  t = sb[d][j]; t.data = '0; t.coll = 1'b0; t.mask = '0; sb[d][j] = t;
               end
            end
         end else begin
            e.data = d_or;
            e.coll = CD && ($countones(act) >= 2);
            e.mask = act;
         end
         sb[d].push_back(e);
      end
      @(negedge okClk);
   endtask

   initial begin : monitor
      logic [15:0]  m_cnt    [2];
      bit           m_sticky [2];
      logic [N-1:0] m_chan   [2];
      bit           p_coll   [2];
      logic [N-1:0] p_mask   [2];
      entry_t       e;
      int           m;
      bit           c, r;
      for (int d = 0; d < 2; d++) begin
         m_cnt[d] = '0; m_sticky[d] = 1'b0; m_chan[d] = '0; p_coll[d] = 1'b0; p_mask[d] = '0;
      end
      forever begin
         @(negedge okClk);
         m = edge_cnt;
         r = rst_at.exists(m) ? rst_at[m] : 1'b0;
         c = clr_at.exists(m) ? clr_at[m] : 1'b0;
         for (int d = 0; d < 2; d++) begin
            if (r) begin
               m_cnt[d] = '0; m_sticky[d] = 1'b0; m_chan[d] = '0;
            end else if (CD) begin
               if (c) begin
                  m_cnt[d]    = p_coll[d] ? 16'd1 : 16'd0;
                  m_sticky[d] = p_coll[d];
                  m_chan[d]   = p_coll[d] ? p_mask[d] : '0;
               end else if (p_coll[d]) begin
                  if (m_cnt[d] != 16'hFFFF) m_cnt[d] = m_cnt[d] + 16'd1;
                  if (!m_sticky[d]) m_chan[d] = p_mask[d];
                  m_sticky[d] = 1'b1;
               end
            end
            check("coll_count",  d, 128'(cnt[d]),    128'(m_cnt[d]));
            check("coll_sticky", d, 128'(sticky[d]), 128'(m_sticky[d]));
            check("coll_chan",   d, 128'(chan[d]),   128'(m_chan[d]));
            p_coll[d] = 1'b0;
            p_mask[d] = '0;
            if (sb[d].size() > 0 && sb[d][0].emerge == m) begin
               e = sb[d].pop_front();
               check("okEH",      d, 128'(eh[d]),   128'(e.data));
               check("collision", d, 128'(coll[d]), 128'(e.coll));
               p_coll[d] = e.coll;
               p_mask[d] = e.mask;
            end else if (m >= stg(d)) begin
               n_cmp++;
               n_err++;
               $display("FAIL scoreboard dut%0d edge %0d: got no expected word, required one", d, m);
            end
         end
      end
   end

   initial begin : stim
      okRst_n = 1'b0; okEHx = '0; chan_en = '0; clr_stat = 1'b0;
      repeat (3) step(1, 4'hF, '0, 0);
      // single channel passes through untouched
      step(0, 4'hF, mk(0, 0, 65'h1_0000_0000_0000_00A5, 0), 0);
      repeat (2) step(0, 4'hF, '0, 0);
      // channels 0 and 3 collide
      step(0, 4'hF, mk(65'h1, 0, 0, 65'h100), 0);
      repeat (3) step(0, 4'hF, '0, 0);
      // same data, channel 3 masked off
      step(0, 4'b0111, mk(65'h1, 0, 0, 65'h100), 0);
      repeat (3) step(0, 4'hF, '0, 0);
      // later collision must not move coll_chan
      step(0, 4'hF, mk(0, 65'h5, 65'h7, 0), 0);
      repeat (3) step(0, 4'hF, '0, 0);
      // clear alone
      step(0, 4'hF, '0, 1);
      repeat (3) step(0, 4'hF, '0, 0);
      // clear held across the collision pulse of both instances
      step(0, 4'hF, mk(65'h3, 65'h3, 0, 0), 0);
      repeat (4) step(0, 4'hF, '0, 1);
      repeat (3) step(0, 4'hF, '0, 0);
      // random traffic
      repeat (600) begin
         step(($urandom_range(0, 59) == 0), 4'($urandom),
              mk(rnd_slice(), rnd_slice(), rnd_slice(), rnd_slice()),
              ($urandom_range(0, 11) == 0));
      end
      // reset with two colliding words in flight
      repeat (2) step(0, 4'hF, '0, 0);
      step(0, 4'hF, mk(65'h11, 65'h22, 0, 0), 0);
      step(0, 4'hF, mk(0, 0, 65'h44, 65'h88), 0);
      step(1, 4'hF, mk(65'h9, 65'h9, 65'h9, 65'h9), 0);
      repeat (4) step(0, 4'hF, '0, 0);
      // drive the counter into saturation
      repeat (65540) step(0, 4'hF, mk(65'h1, 65'h2, 0, 0), 0);
      repeat (4) step(0, 4'hF, '0, 0);
      step(0, 4'hF, '0, 1);
      repeat (3) step(0, 4'hF, '0, 0);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
